mesm6_uart_loader: RTL and testbench
====================================

# mesm6_uart_loader

Serial boot loader that sits directly downstream of the MESM-6 UART unit and acts as a bus master on its register port. After a start pulse it programs the UART control register, polls the UART DATA register for received bytes, parses a framed load image, and assembles each group of six bytes into one 48-bit word. It writes each word into main memory at consecutive addresses, then reports completion or error to the system controller.

## Interface
- `UART_BASE`, 15'o0, UART register window base; register offset is OR-ed into bits [2:0].
- `DIVIDER`, 9'd26, value written to UART CTRL[8:0]; 16·(DIVIDER+1) clocks per bit.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  one-cycle load request; accepted only when not busy.
- `o_busy`  out  1  load in progress.
- `o_done`  out  1  load finished (success or error); held until next accepted start.
- `o_err`  out  1  bad magic or checksum mismatch; valid while `o_done`=1.
- `o_words`  out  16  number of words written in the current/last load.
- `u_addr`  out  15  UART register address.
- `u_rd`  out  1  UART read strobe.
- `u_wr`  out  1  UART write strobe.
- `u_wdata`  out  48  UART write data.
- `u_rdata`  in  48  UART read data; bit 8 = rx_empty, bits [7:0] = byte.
- `u_done`  in  1  UART access complete; 1 cycle after strobe, `u_rdata` valid in that cycle.
- `m_addr`  out  15  memory word address.
- `m_wdata`  out  48  memory write data.
- `m_wr`  out  1  memory write request; level, held until `m_done`.
- `m_done`  in  1  memory write acknowledge.

## Operation
- Image format, bytes in order: magic 8'hA5; address hi (bits [6:0] used, bit 7 ignored); address lo; count hi; count lo; count×6 data bytes, MSB first per word; one checksum byte = XOR of all data bytes. The header is not covered by the checksum.
- FSM states:
  - IDLE: on `i_start`, go to CFG_WR.
  - CFG_WR: one cycle; `u_wr`=1, `u_addr`=UART_BASE|7, `u_wdata`=48'h200|DIVIDER (rxtx_en set, self_test clear).
  - CFG_WAIT: wait for `u_done`.
  - POLL_RD: one cycle; `u_rd`=1, `u_addr`=UART_BASE|0.
  - POLL_WAIT: strobes low; wait for `u_done`.
    - If `u_rdata[8]`=1 (empty), return to POLL_RD.
    - Otherwise pass the byte to PARSE.
  - PARSE: one cycle; consume the byte according to the byte index.
  - MEM_WR: hold `m_wr`=1 with stable `m_addr`/`m_wdata` until `m_done`.
  - FINISH: one cycle; set `o_done`, drop `o_busy`, go to IDLE.
- Parsing rules:
  - Magic ≠ A5: set `o_err`, go to FINISH.
  - Count 0: next byte is the checksum.
  - Sixth byte of a word: go to MEM_WR. On `m_done`, `o_words`+1 and address+1, then POLL_RD, or checksum fetch after the last word.
  - Checksum: `o_err` = (received ≠ accumulated XOR); then FINISH.
- Arithmetic:
  - Memory address wraps modulo 2^15: 15'o77777+1 = 0.
  - Word assembly shifts left 8 per byte; the first byte lands in [47:40].
  - Count is unsigned 16-bit, 0..65535.
- `i_start` while busy: ignored. `i_start` in FINISH: ignored.
- An accepted start clears `o_done`, `o_err`, `o_words`, the XOR accumulator and the byte index.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE.
  - `u_rd`=`u_wr`=`m_wr`=0; `o_busy`=`o_done`=`o_err`=0; `o_words`=0.
  - `u_addr`=`m_addr`=0; `u_wdata`=`m_wdata`=0.
  - Reset mid-load abandons the transfer with no further strobes; a partially written memory image is left as is.
- `o_busy`=1 from the cycle after `i_start` is accepted through FINISH exclusive.
- UART strobes are exactly one cycle wide and never asserted while `u_done`=1, so back-to-back reads are at least 2 cycles apart. Minimum per byte: 3 cycles (POLL_RD, POLL_WAIT, PARSE).
- `m_wr` rises in the cycle after PARSE of the sixth byte and falls in the cycle after `m_done` is sampled high. `m_done` may arrive in the same cycle `m_wr` rises.
- Config write precedes the first poll; exactly one config write per load.

## Test plan
- Config: reset, DIVIDER=26, pulse `i_start` → first bus op is `u_wr` to addr 7 with wdata 48'h21A; `u_rd` is not seen before `u_done`.
- Normal load: stream A5 00 40 00 02, then words 48'h0123456789AB and 48'hFEDCBA987654, then checksum = XOR of the 12 bytes. Required response:
  - `m_wr` to 15'o100 with 48'h0123456789AB, then to 15'o101 with 48'hFEDCBA987654.
  - `o_done`=1, `o_err`=0, `o_words`=2.
- Empty polling: model returns `u_rdata[8]`=1 for 5 reads before each byte → identical memory result; exactly 5 extra `u_rd` pulses per byte.
- Bad magic 8'h5A → `o_done`=1, `o_err`=1, `o_words`=0, no `m_wr`. Bad checksum on the normal load → both words written, `o_err`=1.
- Wrap and memory stall: address 7F FF, count 2; `m_done` delayed 4 cycles → writes at 15'o77777 then 15'o0; `m_wr` held stable for 5 cycles each.
- Reset mid-word (after 3 data bytes) → all strobes 0 asynchronously. A new start then runs a clean load with `o_words` restarting at 0.

Source files
------------

// File: rtl/mesm6_uart_loader.sv
// Serial boot loader: configures the MESM-6 UART, polls received bytes, parses a
// framed image and writes assembled 48-bit words into main memory.
module mesm6_uart_loader #(
  parameter logic [14:0] UART_BASE = 15'o0,
  parameter logic [8:0]  DIVIDER   = 9'd26
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [15:0] o_words,
  output logic [14:0] u_addr,
  output logic        u_rd,
  output logic        u_wr,
  output logic [47:0] u_wdata,
  input  logic [47:0] u_rdata,
  input  logic        u_done,
  output logic [14:0] m_addr,
  output logic [47:0] m_wdata,
  output logic        m_wr,
  input  logic        m_done
);

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 48;
  localparam int unsigned CW = 16;

  localparam logic [2:0] IDX_MAGIC = 3'd0;
  localparam logic [2:0] IDX_AHI   = 3'd1;
  localparam logic [2:0] IDX_ALO   = 3'd2;
  localparam logic [2:0] IDX_CHI   = 3'd3;
  localparam logic [2:0] IDX_CLO   = 3'd4;
  localparam logic [2:0] IDX_DATA  = 3'd5;
  localparam logic [2:0] IDX_SUM   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG_WR, S_CFG_WAIT, S_POLL_RD, S_POLL_WAIT, S_PARSE, S_MEM_WR, S_FINISH
  } state_e;

  state_e        state_q, state_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [CW-1:0] words_q, words_d;
  logic [AW-1:0] u_addr_q, u_addr_d;
  logic          u_rd_q, u_rd_d, u_wr_q, u_wr_d;
  logic [DW-1:0] u_wdata_q, u_wdata_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic          m_wr_q, m_wr_d;
  logic [7:0]    byte_q, byte_d, xor_q, xor_d;
  logic [2:0]    idx_q, idx_d, wb_q, wb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [39:0]   word_q, word_d;
  logic          poll_next, finish_next;
  logic          unused_rdata;

  assign unused_rdata = ^u_rdata[47:9];

  // Next-state and next-output logic; all bus outputs are registered.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    words_d     = words_q;
    u_addr_d    = u_addr_q;
    u_rd_d      = 1'b0;
    u_wr_d      = 1'b0;
    u_wdata_d   = u_wdata_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    m_wr_d      = m_wr_q;
    byte_d      = byte_q;
    xor_d       = xor_q;
    idx_d       = idx_q;
    wb_d        = wb_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    word_d      = word_q;
    poll_next   = 1'b0;
    finish_next = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d   = S_CFG_WR;
          u_wr_d    = 1'b1;
          u_addr_d  = UART_BASE | AW'(7);
          u_wdata_d = DW'(12'h200) | DW'(DIVIDER);
          busy_d    = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          words_d   = '0;
          xor_d     = '0;
          idx_d     = IDX_MAGIC;
          wb_d      = '0;
        end
      end
      S_CFG_WR:   state_d = S_CFG_WAIT;
      S_CFG_WAIT: if (u_done) poll_next = 1'b1;
      S_POLL_RD:  state_d = S_POLL_WAIT;
      S_POLL_WAIT: begin
        if (u_done) begin
          if (u_rdata[8]) begin
            poll_next = 1'b1;
          end else begin
            byte_d  = u_rdata[7:0];
            state_d = S_PARSE;
          end
        end
      end
      S_PARSE: begin
        case (idx_q)
          IDX_MAGIC: begin
            if (byte_q != 8'hA5) begin
              err_d       = 1'b1;
              finish_next = 1'b1;
            end else begin
              idx_d     = IDX_AHI;
              poll_next = 1'b1;
            end
          end
          IDX_AHI: begin
            addr_d[14:8] = byte_q[6:0];
            idx_d        = IDX_ALO;
            poll_next    = 1'b1;
          end
          IDX_ALO: begin
            addr_d[7:0] = byte_q;
            idx_d       = IDX_CHI;
            poll_next   = 1'b1;
          end
          IDX_CHI: begin
            cnt_d[15:8] = byte_q;
            idx_d       = IDX_CLO;
            poll_next   = 1'b1;
          end
          IDX_CLO: begin
            cnt_d[7:0] = byte_q;
            idx_d      = ({cnt_q[15:8], byte_q} == '0) ? IDX_SUM : IDX_DATA;
            poll_next  = 1'b1;
          end
          IDX_DATA: begin
            word_d = {word_q[31:0], byte_q};
            xor_d  = xor_q ^ byte_q;
            if (wb_q == 3'd5) begin
              wb_d      = '0;
              cnt_d     = cnt_q - CW'(1);
              m_wr_d    = 1'b1;
              m_addr_d  = addr_q;
              m_wdata_d = {word_q, byte_q};
              state_d   = S_MEM_WR;
            end else begin
              wb_d      = wb_q + 3'd1;
              poll_next = 1'b1;
            end
          end
          IDX_SUM: begin
            err_d       = (byte_q != xor_q);
            finish_next = 1'b1;
          end
          default: finish_next = 1'b1;
        endcase
      end
      S_MEM_WR: begin
        if (m_done) begin
          m_wr_d    = 1'b0;
          words_d   = words_q + CW'(1);
          addr_d    = addr_q + AW'(1);
          if (cnt_q == '0) idx_d = IDX_SUM;
          poll_next = 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (poll_next) begin
      state_d  = S_POLL_RD;
      u_rd_d   = 1'b1;
      u_addr_d = UART_BASE | AW'(0);
    end
    // Done is visible during FINISH itself, busy drops on the same edge.
    if (finish_next) begin
      state_d = S_FINISH;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      words_q   <= '0;
      u_addr_q  <= '0;
      u_rd_q    <= 1'b0;
      u_wr_q    <= 1'b0;
      u_wdata_q <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wr_q    <= 1'b0;
      byte_q    <= '0;
      xor_q     <= '0;
      idx_q     <= '0;
      wb_q      <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      word_q    <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      words_q   <= words_d;
      u_addr_q  <= u_addr_d;
      u_rd_q    <= u_rd_d;
      u_wr_q    <= u_wr_d;
      u_wdata_q <= u_wdata_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wr_q    <= m_wr_d;
      byte_q    <= byte_d;
      xor_q     <= xor_d;
      idx_q     <= idx_d;
      wb_q      <= wb_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      word_q    <= word_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_err   = err_q;
  assign o_words = words_q;
  assign u_addr  = u_addr_q;
  assign u_rd    = u_rd_q;
  assign u_wr    = u_wr_q;
  assign u_wdata = u_wdata_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wr    = m_wr_q;

endmodule

// File: tb/tb_mesm6_uart_loader.sv
// Bench for mesm6_uart_loader: UART/memory models plus a write scoreboard.
module tb_mesm6_uart_loader;

  typedef struct packed {
    logic [14:0] a;
    logic [47:0] d;
  } wr_t;

  localparam logic [47:0] W0 = 48'h0123456789AB;
  localparam logic [47:0] W1 = 48'hFEDCBA987654;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_start = 1'b0;
  logic        o_busy, o_done, o_err;
  logic [15:0] o_words;
  logic [14:0] u_addr, m_addr;
  logic        u_rd, u_wr, m_wr, m_done;
  logic [47:0] u_wdata, m_wdata;
  logic [47:0] u_rdata;
  logic        u_done;

  int total = 0;
  int bad = 0;

  logic [7:0] rx_q[$];
  wr_t        exp_q[$];
  int         hold_q[$];
  int         empties_cfg = 0;
  int         empty_left = 0;
  int         mem_delay = 0;
  int         wr_cnt = 0;

  int          nrd, nwr, nmw, first_op, conflict;
  bit          early_rd, seen_udone, timed_out;
  logic [14:0] cfg_a;
  logic [47:0] cfg_d;

  mesm6_uart_loader dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_words(o_words),
    .u_addr(u_addr), .u_rd(u_rd), .u_wr(u_wr), .u_wdata(u_wdata),
    .u_rdata(u_rdata), .u_done(u_done),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wr(m_wr), .m_done(m_done)
  );

  always #5 clk = ~clk;

  // UART model: one-cycle access latency, optional empty reads before each byte.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      u_done  <= 1'b0;
      u_rdata <= '0;
    end else begin
      u_done <= 1'b0;
      if (u_rd || u_wr) begin
        u_done  <= 1'b1;
        u_rdata <= 48'h100;
        if (u_rd) begin
          if (empty_left > 0) begin
            empty_left = empty_left - 1;
          end else if (rx_q.size() > 0) begin
            u_rdata    <= {40'h0, rx_q.pop_front()};
            empty_left = empties_cfg;
          end
        end
      end
    end
  end

  // Memory model: acknowledge after mem_delay cycles of m_wr.
  assign m_done = m_wr && (wr_cnt >= mem_delay);
  always @(posedge clk) begin
    if (m_wr && !m_done) wr_cnt <= wr_cnt + 1;
    else                 wr_cnt <= 0;
  end

  task automatic load_image(input logic [7:0] magic, input logic [15:0] addr,
                            input logic [15:0] n, input bit bad_sum);
    logic [7:0]  x;
    logic [7:0]  b;
    logic [47:0] w;
    logic [14:0] a;
    rx_q.delete();
    exp_q.delete();
    x = 8'h00;
    a = addr[14:0];
    rx_q.push_back(magic);
    rx_q.push_back(addr[15:8]);
    rx_q.push_back(addr[7:0]);
    rx_q.push_back(n[15:8]);
    rx_q.push_back(n[7:0]);
    for (int i = 0; i < int'(n); i++) begin
      w = (i % 2 == 0) ? W0 : W1;
      for (int k = 0; k < 6; k++) begin
        b = w[47 - 8*k -: 8];
        rx_q.push_back(b);
        x = x ^ b;
      end
      if (magic == 8'hA5) exp_q.push_back('{a: a, d: w});
      a = a + 15'd1;
    end
    rx_q.push_back(bad_sum ? (x ^ 8'h3C) : x);
    empty_left = empties_cfg;
  endtask

  // Pulse start and watch the bus until o_done; writes are scoreboarded here.
  task automatic run_load(input bit poke);
    bit          fin;
    bit          pm;
    int          hold;
    logic [14:0] pa;
    logic [47:0] pd;
    wr_t         e;
    nrd = 0; nwr = 0; nmw = 0; first_op = 0; conflict = 0;
    early_rd = 0; seen_udone = 0; timed_out = 0;
    hold_q.delete();
    hold = 0; pm = 0; pa = '0; pd = '0; fin = 0;
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (u_wr) begin
        nwr++;
        if (first_op == 0) first_op = 1;
        cfg_a = u_addr;
        cfg_d = u_wdata;
      end
      if (u_rd) begin
        nrd++;
        if (first_op == 0) first_op = 2;
        if (!seen_udone) early_rd = 1;
      end
      if (u_done) seen_udone = 1;
      if ((u_rd || u_wr) && u_done) conflict++;
      if (m_wr) begin
        hold++;
        if (pm) begin
          total++;
          if (m_addr !== pa || m_wdata !== pd) begin
            bad++;
            $display("FAIL m_wr_stable: addr=%o data=%h, required addr=%o data=%h", m_addr, m_wdata, pa, pd);
          end
        end
        pa = m_addr;
        pd = m_wdata;
        if (m_done) begin
          nmw++;
          hold_q.push_back(hold);
          hold = 0;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL mem_write: unexpected write addr=%o data=%h", m_addr, m_wdata);
          end else begin
            e = exp_q.pop_front();
            if ({m_addr, m_wdata} !== {e.a, e.d}) begin
              bad++;
              $display("FAIL mem_write: got addr=%o data=%h, required addr=%o data=%h", m_addr, m_wdata, e.a, e.d);
            end
          end
        end
      end
      pm = m_wr;
      if (o_done) fin = 1;
      i_start = (poke && cyc == 25) ? 1'b1 : 1'b0;
      if (!fin) @(negedge clk);
    end
    i_start = 1'b0;
    total++;
    if (!fin) begin
      bad++;
      timed_out = 1;
      $display("FAIL load_timeout: o_done=%b after 3000 cycles, required 1", o_done);
    end
  endtask

  task automatic check_result(input string nm, input bit err_exp, input logic [15:0] words_exp);
    total++;
    if ({o_done, o_busy, o_err} !== {1'b1, 1'b0, err_exp}) begin
      bad++;
      $display("FAIL %s_status: done/busy/err=%b%b%b, required 10%b", nm, o_done, o_busy, o_err, err_exp);
    end
    total++;
    if (o_words !== words_exp) begin
      bad++;
      $display("FAIL %s_words: o_words=%0d, required %0d", nm, o_words, words_exp);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_writes: %0d pending, required 0", nm, exp_q.size());
    end
  endtask

  task automatic test_reset;
    total++;
    if ({u_rd, u_wr, m_wr, o_busy, o_done, o_err} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: rd/wr/mwr/busy/done/err=%b, required 000000", {u_rd, u_wr, m_wr, o_busy, o_done, o_err});
    end
    total++;
    if ({u_addr, m_addr, o_words, u_wdata, m_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_values: u_addr=%o m_addr=%o words=%0d u_wdata=%h m_wdata=%h, required all 0", u_addr, m_addr, o_words, u_wdata, m_wdata);
    end
  endtask

  task automatic test_normal;
    empties_cfg = 0; mem_delay = 0;
    load_image(8'hA5, 16'h0040, 16'd2, 1'b0);
    run_load(1'b1);
    total++;
    if (first_op !== 1 || early_rd) begin
      bad++;
      $display("FAIL cfg_order: first_op=%0d early_rd=%0d, required 1 and 0", first_op, early_rd);
    end
    total++;
    if (cfg_a !== 15'd7 || cfg_d !== 48'h21A) begin
      bad++;
      $display("FAIL cfg_write: addr=%o data=%h, required 7 and 21a", cfg_a, cfg_d);
    end
    total++;
    if (nwr !== 1 || nrd !== 18 || nmw !== 2 || conflict !== 0) begin
      bad++;
      $display("FAIL normal_counts: wr=%0d rd=%0d mw=%0d conflict=%0d, required 1 18 2 0", nwr, nrd, nmw, conflict);
    end
    check_result("normal", 1'b0, 16'd2);
  endtask

  task automatic test_empty_poll;
    empties_cfg = 5; mem_delay = 0;
    load_image(8'hA5, 16'h0040, 16'd2, 1'b0);
    run_load(1'b0);
    total++;
    if (nrd !== 18 * 6 || nmw !== 2) begin
      bad++;
      $display("FAIL empty_poll_reads: rd=%0d mw=%0d, required 108 2", nrd, nmw);
    end
    check_result("empty_poll", 1'b0, 16'd2);
    empties_cfg = 0;
  endtask

  task automatic test_bad_magic;
    load_image(8'h5A, 16'h0040, 16'd2, 1'b0);
    run_load(1'b0);
    total++;
    if (nmw !== 0 || nrd !== 1) begin
      bad++;
      $display("FAIL bad_magic_bus: mw=%0d rd=%0d, required 0 1", nmw, nrd);
    end
    check_result("bad_magic", 1'b1, 16'd0);
  endtask

  task automatic test_bad_checksum;
    load_image(8'hA5, 16'h0040, 16'd2, 1'b1);
    run_load(1'b0);
    check_result("bad_sum", 1'b1, 16'd2);
  endtask

  task automatic test_wrap_stall;
    mem_delay = 4;
    load_image(8'hA5, 16'h7FFF, 16'd2, 1'b0);
    run_load(1'b0);
    total++;
    if (hold_q.size() != 2) begin
      bad++;
      $display("FAIL wrap_holds: %0d writes, required 2", hold_q.size());
    end else if (hold_q[0] != 5 || hold_q[1] != 5) begin
      bad++;
      $display("FAIL wrap_holds: m_wr held %0d and %0d cycles, required 5 and 5", hold_q[0], hold_q[1]);
    end
    check_result("wrap", 1'b0, 16'd2);
    mem_delay = 0;
  endtask

  task automatic test_reset_midword;
    bit reached;
    load_image(8'hA5, 16'h0040, 16'd2, 1'b0);
    reached = 0;
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    for (int cyc = 0; cyc < 500 && !reached; cyc++) begin
      @(negedge clk);
      if (rx_q.size() <= 10) reached = 1;
    end
    total++;
    if (!reached) begin
      bad++;
      $display("FAIL midword_progress: %0d bytes left, required <= 10", rx_q.size());
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({u_rd, u_wr, m_wr, o_busy} !== 4'b0) begin
      bad++;
      $display("FAIL midword_reset: rd/wr/mwr/busy=%b, required 0000", {u_rd, u_wr, m_wr, o_busy});
    end
    rx_q.delete();
    exp_q.delete();
    @(negedge clk); reset_n = 1'b1;
    load_image(8'hA5, 16'h0040, 16'd2, 1'b0);
    run_load(1'b0);
    check_result("after_reset", 1'b0, 16'd2);
  endtask

  task automatic test_back_to_back;
    load_image(8'hA5, 16'h0010, 16'd0, 1'b0);
    run_load(1'b0);
    total++;
    if (nrd !== 6 || nmw !== 0) begin
      bad++;
      $display("FAIL count0_bus: rd=%0d mw=%0d, required 6 0", nrd, nmw);
    end
    check_result("count0", 1'b0, 16'd0);
    // Start arriving during FINISH must be dropped.
    i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({o_done, o_busy, u_wr} !== 3'b100) begin
      bad++;
      $display("FAIL finish_start: done/busy/u_wr=%b, required 100", {o_done, o_busy, u_wr});
    end
    load_image(8'hA5, 16'h0123, 16'd1, 1'b0);
    run_load(1'b0);
    check_result("b2b", 1'b0, 16'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    test_reset();
    reset_n = 1'b1;
    test_normal();
    test_empty_poll();
    test_bad_magic();
    test_bad_checksum();
    test_wrap_stall();
    test_reset_midword();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
